// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the data-memory bus bridges.
// Lane merge is used by every bridge that does read-modify-write.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } bridge_state_t;

  localparam int DEFAULT_MEM_WORDS = 4096;

  function automatic logic [31:0] be_merge(
    input logic [31:0] nw,
    input logic [31:0] old,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i+:8] = nw[8*i+:8];
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational 4-lane merge of a new word over an old word.
// Lane i takes new_word when be[i] is set.
module byte_lane_merge
  import mips_bus_pkg::*;
(
  input  logic [31:0] new_word,
  input  logic [31:0] old_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  assign merged = be_merge(new_word, old_word, be);

endmodule

// File: rtl/avalon_data_mem_bridge.sv
// Avalon-MM slave in front of the single-port data memory.
// Partial writes merge with the combinational read word in ACCESS.
module avalon_data_mem_bridge
  import mips_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MEM_WORDS   = DEFAULT_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic        bus_err
);

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);
  localparam logic [30:0]   MW = 31'(MEM_WORDS);

  bridge_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          err_q, err_d;

  logic          access;
  logic          oor;
  logic [31:0]   rd_word;
  logic [31:0]   merged;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^address[1:0];

  assign access = (state_q == ACCESS);
  assign oor    = ({1'b0, addr_q} >= MW);
  assign rd_word = oor ? 32'h0 : mem_read_data;

  byte_lane_merge u_merge (
    .new_word (wdata_q),
    .old_word (mem_read_data),
    .be       (be_q),
    .merged   (merged)
  );

  assign mem_address    = {addr_q, 2'b00};
  assign mem_read       = access;
  assign mem_write_data = (be_q == 4'hF) ? wdata_q : merged;
  assign mem_write      = access & we_q & (|be_q) & ~oor;
  assign readdata       = access ? rd_word : readdata_q;
  assign bus_err        = err_q;
  // Gated by reset so a held request reads as idle while in reset.
  assign waitrequest    = reset_n & (read | write) & ~access;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    readdata_d = readdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (read | write) begin
          addr_d  = address[31:2];
          wdata_d = writedata;
          be_d    = byteenable;
          we_d    = write;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
          if (read & write) err_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = IDLE;
        if (oor) err_d = 1'b1;
        if (!we_q) readdata_d = rd_word;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      readdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

endmodule
